err_collector: RTL
==================

Name: err_collector

Overview:
- Sits inside proc and is the producer of the single-bit err that the clock/reset generator samples to end simulation.
- Collects per-stage error flags from the pipeline and holds an error pending until the offending instruction either commits (error becomes fatal) or is flushed (error is discarded).
- Ignores errors for a short window after reset, while the pipeline fills with garbage.
- Reports a sticky err plus source, code and cycle stamp for debug.

Parameters:
- NUM_SRC, 4, number of error sources; index 0 is the most senior stage (closest to writeback).
- CODE_W, 4, width of each source's error code.
- BLANK_CYC, 2, cycles after reset during which src_err is ignored (0 allowed).
- STAMP_W, 16, width of the cycle stamp counter.
- PEND_TIMEOUT, 64, cycles a pending error may wait before escalation (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- src_err  input  NUM_SRC  per-source error flag, bit i = source i.
- src_code  input  NUM_SRC*CODE_W  per-source code; slice i is bits [i*CODE_W +: CODE_W].
- commit  input  1  the instruction owning the pending error retired this cycle.
- flush  input  1  pipeline squash; discards the pending error.
- err  output  1  fatal error, sticky until rst.
- err_src  output  clog2(NUM_SRC), min 1  index of the captured source.
- err_code  output  CODE_W  captured code.
- err_cycle  output  STAMP_W  stamp value at capture.
- blanking  output  1  high while in BLANK.

Behaviour:
Reset (rst=1 at an edge):
- state=BLANK, blank counter=0, stamp=0.
- err=0, err_src=0, err_code=0, err_cycle=0.
- blanking=1 if BLANK_CYC>0, else 0.
- rst has priority over every other input in every state.

Stamp counter:
- Free-running; increments every non-reset cycle.
- Saturates at all-ones (no wrap).

BLANK:
- src_err, commit and flush are ignored.
- Counter increments each cycle; when it reaches BLANK_CYC, go to RUN on that edge and drop blanking.
- BLANK_CYC=0: reset goes straight to RUN.

RUN:
- If flush=1: stay in RUN and ignore src_err this cycle (flush wins).
- Else if any src_err bit is set: capture the lowest set index into err_src, its code into err_code and the current stamp into err_cycle; go to PEND.
- commit is ignored while in RUN.

PEND:
- Priority order: flush, then commit, then replacement.
- flush=1: back to RUN; err_src, err_code and err_cycle keep their last values (debug only).
- Else commit=1: go to FATAL; err=1 from the next edge.
- Else if a src_err bit is set with index strictly lower than err_src: replace source, code and stamp; stay in PEND.
- A same or higher index error in PEND is ignored.

FATAL:
- err=1 and all captured fields frozen until rst.
- All inputs ignored.

Latency:
- src_err asserted at edge t captures at t.
- commit sampled at t+1 gives err=1 after edge t+1.
- err is registered; it never goes high combinationally.

Optional Feature:
- Macro: ERRCOL_PEND_TIMEOUT_EN.
- With the macro: a counter clears on entry to PEND and on each replacement.
- If PEND lasts PEND_TIMEOUT cycles without flush or commit, go to FATAL with err_code forced to all-ones and err_src unchanged.
- Without the macro: PEND waits indefinitely, and PEND_TIMEOUT is unused.

Decomposition:
- Shared include errcol_defs.vh holds:
  - state encodings: BLANK=2'd0, RUN=2'd1, PEND=2'd2, FATAL=2'd3;
  - the all-ones timeout code constant;
  - the clog2 helper.
- One natural sub-module, sat_counter (parameter width; inputs clk, rst, inc; output count saturating at all-ones), reused for the stamp counter and the timeout counter.

Test Plan:
- Blanking: reset, then src_err=4'b0001 on cycles 0-1 with BLANK_CYC=2 -> blanking=1 for 2 cycles, err stays 0, the error is not captured.
- Commit path: src_err=4'b0100 with code slice 2=4'hA at stamp 5, commit the next cycle -> err=1 the following cycle, err_src=2, err_code=4'hA, err_cycle=5.
- Flush discard: capture src 1, then flush=1 and commit=1 in the same cycle -> back in RUN, err=0; a later commit alone still gives err=0.
- Seniority: capture src 3 at stamp 10; src 0 (code 4'h3) at stamp 11 -> replaced with err_src=0, code 4'h3, stamp 11; then src 2 -> ignored.
- Sticky/reset: in FATAL apply flush and new src_err -> nothing changes; assert rst mid-FATAL -> all outputs 0 the next cycle and state BLANK.
- Timeout (macro on, PEND_TIMEOUT=4): capture src 1, no commit or flush for 4 cycles -> err=1, err_code=4'hF, err_src=1. Same stimulus with the macro off -> err stays 0.

Source files
------------

// File: rtl/err_collector_pkg.sv
// Shared definitions for err_collector: FSM state encoding, timeout code, width helper.
package err_collector_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_FATAL = 2'd3
  } errcol_state_e;

  // Code reported when a pending error escalates by timeout (truncate to CODE_W).
  localparam logic [31:0] ERRCOL_TMO_CODE = 32'hFFFF_FFFF;

  // Ceiling log2, never less than 1 so single-entry fields stay 1 bit wide.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/err_collector_sat_counter.sv
// sat_counter: synchronous-clear up-counter that sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold at all-ones, clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/err_collector.sv
// err_collector: holds a pipeline error pending until commit (fatal) or flush (discard).
// Optional macro ERRCOL_PEND_TIMEOUT_EN escalates a pending error after PEND_TIMEOUT cycles.
module err_collector
  import err_collector_pkg::*;
#(
  parameter  int unsigned NUM_SRC      = 4,
  parameter  int unsigned CODE_W       = 4,
  parameter  int unsigned BLANK_CYC    = 2,
  parameter  int unsigned STAMP_W      = 16,
  parameter  int unsigned PEND_TIMEOUT = 64,
  localparam int unsigned SRC_W        = clog2_min1(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_err,
  input  logic [NUM_SRC*CODE_W-1:0] src_code,
  input  logic                      commit,
  input  logic                      flush,
  output logic                      err,
  output logic [SRC_W-1:0]          err_src,
  output logic [CODE_W-1:0]         err_code,
  output logic [STAMP_W-1:0]        err_cycle,
  output logic                      blanking
);

  localparam int unsigned BLK_W    = clog2_min1(BLANK_CYC + 1);
  localparam int unsigned BLK_LAST = (BLANK_CYC == 0) ? 0 : BLANK_CYC - 1;
  localparam int unsigned TMO_W    = clog2_min1(PEND_TIMEOUT + 1);
  localparam int unsigned TMO_LAST = (PEND_TIMEOUT == 0) ? 0 : PEND_TIMEOUT - 1;
  localparam errcol_state_e RST_STATE = (BLANK_CYC == 0) ? ST_RUN : ST_BLANK;
`ifdef ERRCOL_PEND_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  errcol_state_e       state_q, state_d;
  logic [STAMP_W-1:0]  stamp;
  logic [BLK_W-1:0]    blank_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_clr;
  logic                tmo_hit;
  logic                blank_done;
  logic                hit_any;
  logic [SRC_W-1:0]    hit_idx;
  logic [CODE_W-1:0]   hit_code;
  logic [SRC_W-1:0]    src_d;
  logic [CODE_W-1:0]   code_d;
  logic [STAMP_W-1:0]  cycle_d;

  // Free-running saturating cycle stamp.
  sat_counter #(.WIDTH(STAMP_W)) u_stamp (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (stamp)
  );

  // Counts cycles spent in BLANK after reset.
  sat_counter #(.WIDTH(BLK_W)) u_blank (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_q == ST_BLANK),
    .count (blank_cnt)
  );

  // Age of the current pending error; restarts on capture and replacement.
  sat_counter #(.WIDTH(TMO_W)) u_tmo (
    .clk   (clk),
    .rst   (rst | tmo_clr),
    .inc   (state_q == ST_PEND),
    .count (tmo_cnt)
  );

  assign blank_done = (blank_cnt == BLK_W'(BLK_LAST));
  assign tmo_hit    = TMO_EN && (tmo_cnt == TMO_W'(TMO_LAST));

  // Pick the most senior (lowest index) flagged source and its code.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_code = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_err[i]) begin
        hit_any  = 1'b1;
        hit_idx  = SRC_W'(i);
        hit_code = src_code[i*CODE_W +: CODE_W];
      end
    end
  end

  // Next-state and next captured fields.
  always_comb begin
    state_d = state_q;
    src_d   = err_src;
    code_d  = err_code;
    cycle_d = err_cycle;
    tmo_clr = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (blank_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!flush && hit_any) begin
          state_d = ST_PEND;
          src_d   = hit_idx;
          code_d  = hit_code;
          cycle_d = stamp;
          tmo_clr = 1'b1;
        end
      end
      ST_PEND: begin
        if (flush) begin
          state_d = ST_RUN;
        end else if (commit) begin
          state_d = ST_FATAL;
        end else if (hit_any && (hit_idx < err_src)) begin
          src_d   = hit_idx;
          code_d  = hit_code;
          cycle_d = stamp;
          tmo_clr = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_FATAL;
          code_d  = CODE_W'(ERRCOL_TMO_CODE);
        end
      end
      ST_FATAL: begin
        state_d = ST_FATAL;
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_STATE;
      err       <= 1'b0;
      err_src   <= '0;
      err_code  <= '0;
      err_cycle <= '0;
      blanking  <= (BLANK_CYC > 0);
    end else begin
      state_q   <= state_d;
      err       <= (state_d == ST_FATAL);
      err_src   <= src_d;
      err_code  <= code_d;
      err_cycle <= cycle_d;
      blanking  <= (state_d == ST_BLANK);
    end
  end

endmodule
